// File: rtl/cam_frame_gen.sv
// cam_frame_gen: OV7670-style QQVGA RGB444 camera emulator, pclk = clk/2.
// Optional feature macro CAM_GEN_STRIPES_EN enables the stripes pattern (pattern=2).
module cam_frame_gen #(
  parameter int TAM_LINE       = 320,
  parameter int TAM_ROW        = 120,
  parameter int BLACK_TAM_LINE = 4,
  parameter int BLACK_TAM_ROW  = 4,
  parameter int VSYNC_ROWS     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern,
  input  logic [11:0] color,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [8:0] LINE_LAST = 9'(TAM_LINE + BLACK_TAM_LINE - 1);
  localparam logic [8:0] LINE_ACT  = 9'(TAM_LINE);
  localparam logic [8:0] ACT_LAST  = 9'(TAM_LINE - 1);
  localparam logic [6:0] ROW_LAST  = 7'(TAM_ROW + BLACK_TAM_ROW - 1);
  localparam logic [6:0] ROW_BLK   = 7'(BLACK_TAM_ROW);
  localparam logic [6:0] ROW_VS    = 7'(VSYNC_ROWS);

  logic        phase_r;
  logic [0:0]  state_r;
  logic [8:0]  line_r;
  logic [6:0]  row_r;
  logic [1:0]  pat_r;
  logic [11:0] col_r;
  logic        vsync_r;
  logic        href_r;
  logic [7:0]  data_r;
  logic        drop_r;
  logic        frame_done_r;
  logic [7:0]  frame_cnt_r;

  logic        tick_s;
  logic        drop_s;
  logic        latch_s;
  logic        run_nx_s;
  logic [0:0]  state_nx_s;
  logic [8:0]  line_nx_s;
  logic [6:0]  row_nx_s;
  logic [1:0]  pat_use_s;
  logic [11:0] col_use_s;
  logic [11:0] pix_s;
  logic        vsync_nx_s;
  logic        href_nx_s;
  logic [7:0]  byte_nx_s;

  function automatic logic [11:0] bar_color(input logic [7:0] x);
    logic [11:0] c;
    if (x < 8'd20)       c = 12'hFFF;
    else if (x < 8'd40)  c = 12'hFF0;
    else if (x < 8'd60)  c = 12'h0FF;
    else if (x < 8'd80)  c = 12'h0F0;
    else if (x < 8'd100) c = 12'hF0F;
    else if (x < 8'd120) c = 12'hF00;
    else if (x < 8'd140) c = 12'h00F;
    else                 c = 12'h000;
    return c;
  endfunction

`ifdef CAM_GEN_STRIPES_EN
  function automatic logic [11:0] stripe_color(input logic [6:0] y);
    logic [11:0] c;
    if (y < 7'd15)       c = 12'hF0F;
    else if (y < 7'd45)  c = 12'h0F0;
    else if (y < 7'd75)  c = 12'hF0F;
    else if (y < 7'd105) c = 12'h0F0;
    else                 c = 12'hF0F;
    return c;
  endfunction
`endif

  // Everything moves on the clk where pclk falls, so data is stable at pclk rise.
  assign tick_s = phase_r;
  assign drop_s = tick_s && (state_r == ST_RUN) && (row_r == ROW_LAST) && (line_r == ACT_LAST);

  // Next state and raster position, applied on tick
  always_comb begin
    state_nx_s = state_r;
    line_nx_s  = line_r;
    row_nx_s   = row_r;
    latch_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        line_nx_s = 9'd0;
        row_nx_s  = 7'd0;
        if (en) begin
          state_nx_s = ST_RUN;
          latch_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (line_r == LINE_LAST) begin
          line_nx_s = 9'd0;
          if (row_r == ROW_LAST) begin
            row_nx_s = 7'd0;
            if (en) latch_s = 1'b1;
            else    state_nx_s = ST_IDLE;
          end else begin
            row_nx_s = row_r + 7'd1;
          end
        end else begin
          line_nx_s = line_r + 9'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        line_nx_s  = 9'd0;
        row_nx_s   = 7'd0;
      end
    endcase
  end

  // Sync flags and outgoing byte for the position being entered
  always_comb begin
    pat_use_s  = latch_s ? pattern : pat_r;
    col_use_s  = latch_s ? color : col_r;
    run_nx_s   = (state_nx_s == ST_RUN);
    vsync_nx_s = run_nx_s && (row_nx_s < ROW_VS);
    href_nx_s  = run_nx_s && (row_nx_s >= ROW_BLK) && (line_nx_s < LINE_ACT);
    case (pat_use_s)
      2'd1: pix_s = bar_color(line_nx_s[8:1]);
`ifdef CAM_GEN_STRIPES_EN
      2'd2: pix_s = stripe_color(row_nx_s - ROW_BLK);
`endif
      default: pix_s = col_use_s;
    endcase
    if (!href_nx_s)        byte_nx_s = 8'h00;
    else if (line_nx_s[0]) byte_nx_s = pix_s[7:0];
    else                   byte_nx_s = {4'h0, pix_s[11:8]};
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r      <= 1'b0;
      state_r      <= ST_IDLE;
      line_r       <= 9'd0;
      row_r        <= 7'd0;
      pat_r        <= 2'd0;
      col_r        <= 12'h000;
      vsync_r      <= 1'b0;
      href_r       <= 1'b0;
      data_r       <= 8'h00;
      drop_r       <= 1'b0;
      frame_done_r <= 1'b0;
      frame_cnt_r  <= 8'd0;
    end else begin
      phase_r      <= ~phase_r;
      drop_r       <= drop_s;
      frame_done_r <= drop_r;
      if (drop_r) frame_cnt_r <= frame_cnt_r + 8'd1;
      if (tick_s) begin
        state_r <= state_nx_s;
        line_r  <= line_nx_s;
        row_r   <= row_nx_s;
        vsync_r <= vsync_nx_s;
        href_r  <= href_nx_s;
        data_r  <= byte_nx_s;
        if (latch_s) begin
          pat_r <= pattern;
          col_r <= color;
        end
      end
    end
  end

  assign CAM_pclk    = phase_r;
  assign CAM_vsync   = vsync_r;
  assign CAM_href    = href_r;
  assign CAM_px_data = data_r;
  assign frame_done  = frame_done_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_cam_frame_gen.sv
// Bench for cam_frame_gen: a 4-active-row instance for raster/pattern checks and
// a tiny-geometry instance for latency scaling and the 8-bit frame counter wrap.
module tb_cam_frame_gen;

  localparam int FRAME_TICKS = 8 * 324;

  logic clk = 1'b0;
  logic rst, en, en2;
  logic [1:0]  pattern;
  logic [11:0] color;
  logic        CAM_pclk, CAM_vsync, CAM_href, frame_done;
  logic [7:0]  CAM_px_data, frame_cnt;
  logic        pclk2, vsync2, href2, done2;
  logic [7:0]  data2, cnt2;

  always #5 clk = ~clk;

  cam_frame_gen #(.TAM_LINE(320), .TAM_ROW(4), .BLACK_TAM_LINE(4), .BLACK_TAM_ROW(4), .VSYNC_ROWS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .pattern(pattern), .color(color),
    .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
    .CAM_px_data(CAM_px_data), .frame_done(frame_done), .frame_cnt(frame_cnt));

  cam_frame_gen #(.TAM_LINE(4), .TAM_ROW(2), .BLACK_TAM_LINE(2), .BLACK_TAM_ROW(2), .VSYNC_ROWS(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .pattern(pattern), .color(color),
    .CAM_pclk(pclk2), .CAM_vsync(vsync2), .CAM_href(href2),
    .CAM_px_data(data2), .frame_done(done2), .frame_cnt(cnt2));

`ifdef CAM_GEN_STRIPES_EN
  localparam logic [7:0] P2_B0 = 8'h0F;
  localparam logic [7:0] P2_B1 = 8'h0F;
`else
  localparam logic [7:0] P2_B0 = 8'h01;
  localparam logic [7:0] P2_B1 = 8'h23;
`endif

  typedef struct {
    int         frame;
    int         px;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t        vecs [17];
  logic [1:0]  cfg_pat [5];
  logic [11:0] cfg_col [5];
  logic [7:0]  cap [320];

  int n_chk = 0;
  int n_fail = 0;
  int done_seen, vs_cnt, href_cnt, lines, first_href, bad0, nbytes;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
    if (frame_done) done_seen++;
  endtask

  // Advance to the next clk where pclk fell; bounded so a stuck pclk cannot hang.
  task automatic next_tick();
    int g;
    g = 0;
    do begin
      step_clk();
      g++;
    end while (CAM_pclk !== 1'b0 && g < 4);
  endtask

  // Walk one full frame starting at its row-0/line-0 tick; change inputs mid-frame.
  task automatic scan_frame(input logic [1:0] np, input logic [11:0] nc, input logic nen);
    logic prev_h;
    vs_cnt = 0; href_cnt = 0; lines = 0; first_href = -1; bad0 = 0; nbytes = 0;
    done_seen = 0; prev_h = 1'b0;
    for (int t = 0; t < FRAME_TICKS; t++) begin
      if (t > 0) next_tick();
      if (t == 1400) begin
        pattern = np; color = nc; en = nen;
      end
      if (CAM_vsync) vs_cnt++;
      if (CAM_href) begin
        href_cnt++;
        if (!prev_h) lines++;
        if (first_href < 0) first_href = t;
        if (nbytes < 320) begin
          cap[nbytes] = CAM_px_data;
          nbytes++;
        end
      end else if (CAM_px_data != 8'h00) begin
        bad0++;
      end
      prev_h = CAM_href;
    end
  endtask

  initial begin
    int lat, pulses, cnt255, guard;

    vecs[0]  = '{0, 0,   8'h0F, 8'h00};
    vecs[1]  = '{0, 159, 8'h0F, 8'h00};
    vecs[2]  = '{1, 0,   8'h00, 8'hF0};
    vecs[3]  = '{1, 100, 8'h00, 8'hF0};
    vecs[4]  = '{2, 0,   8'h0F, 8'hFF};
    vecs[5]  = '{2, 19,  8'h0F, 8'hFF};
    vecs[6]  = '{2, 20,  8'h0F, 8'hF0};
    vecs[7]  = '{2, 40,  8'h00, 8'hFF};
    vecs[8]  = '{2, 60,  8'h00, 8'hF0};
    vecs[9]  = '{2, 80,  8'h0F, 8'h0F};
    vecs[10] = '{2, 100, 8'h0F, 8'h00};
    vecs[11] = '{2, 120, 8'h00, 8'h0F};
    vecs[12] = '{2, 139, 8'h00, 8'h0F};
    vecs[13] = '{2, 140, 8'h00, 8'h00};
    vecs[14] = '{2, 159, 8'h00, 8'h00};
    vecs[15] = '{3, 77,  8'h05, 8'hA3};
    vecs[16] = '{4, 0,   P2_B0, P2_B1};
    cfg_pat = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
    cfg_col = '{12'hF00, 12'h0F0, 12'h000, 12'h5A3, 12'h123};

    rst = 1'b1; en = 1'b0; en2 = 1'b0; pattern = 2'd0; color = 12'h000; done_seen = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst pclk", CAM_pclk, 0);
    chk("rst vsync/href", {CAM_vsync, CAM_href}, 0);
    chk("rst data", CAM_px_data, 0);
    chk("rst done/cnt", {frame_done, frame_cnt}, 0);
    rst = 1'b0;
    step_clk();
    chk("pclk rise after rst", CAM_pclk, 1);
    step_clk();
    chk("pclk fall after rst", CAM_pclk, 0);

    pattern = cfg_pat[0]; color = cfg_col[0]; en = 1'b1;
    next_tick();
    chk("start vsync", CAM_vsync, 1);
    chk("start href", CAM_href, 0);

    for (int f = 0; f < 5; f++) begin
      if (f < 4) scan_frame(cfg_pat[f+1], cfg_col[f+1], 1'b1);
      else       scan_frame(cfg_pat[4], cfg_col[4], 1'b0);
      chk($sformatf("f%0d first href tick", f), first_href, 1296);
      chk($sformatf("f%0d href ticks", f), href_cnt, 1280);
      chk($sformatf("f%0d lines", f), lines, 4);
      chk($sformatf("f%0d vsync ticks", f), vs_cnt, 648);
      chk($sformatf("f%0d data nonzero with href low", f), bad0, 0);
      chk($sformatf("f%0d frame_done pulses", f), done_seen, 1);
      chk($sformatf("f%0d frame_cnt", f), frame_cnt, f + 1);
      for (int v = 0; v < 17; v++) begin
        if (vecs[v].frame == f) begin
          chk($sformatf("f%0d px%0d byte0", f, vecs[v].px), cap[2*vecs[v].px], vecs[v].b0);
          chk($sformatf("f%0d px%0d byte1", f, vecs[v].px), cap[2*vecs[v].px+1], vecs[v].b1);
        end
      end
      next_tick();
      if (f < 4) chk($sformatf("f%0d next vsync", f), CAM_vsync, 1);
    end

    bad0 = 0; done_seen = 0;
    for (int t = 0; t < 700; t++) begin
      if (t > 0) next_tick();
      if (CAM_vsync || CAM_href || CAM_px_data != 8'h00) bad0++;
    end
    chk("idle quiet", bad0, 0);
    chk("idle no done", done_seen, 0);
    chk("idle frame_cnt", frame_cnt, 5);

    en = 1'b1;
    next_tick();
    chk("restart vsync", CAM_vsync, 1);
    chk("restart href", CAM_href, 0);
    for (int t = 0; t < 1700; t++) next_tick();
    chk("row5 href", CAM_href, 1);
    chk("row5 byte", CAM_px_data, P2_B0);

    rst = 1'b1;
    step_clk();
    chk("midrst sync", {CAM_pclk, CAM_vsync, CAM_href}, 0);
    chk("midrst data", CAM_px_data, 0);
    chk("midrst cnt", {frame_done, frame_cnt}, 0);
    rst = 1'b0; en = 1'b0;
    bad0 = 0;
    for (int t = 0; t < 10; t++) begin
      next_tick();
      if (CAM_vsync || CAM_href) bad0++;
    end
    chk("post-rst idle", bad0, 0);

    en2 = 1'b1;
    next_tick();
    chk("tiny start vsync", vsync2, 1);
    chk("tiny tick pclk", pclk2, 0);
    lat = 0;
    while (href2 !== 1'b1 && lat < 50) begin
      next_tick();
      lat++;
    end
    chk("tiny first href latency", lat, 12);
    chk("tiny first byte", data2, P2_B0);

    pulses = 0; cnt255 = -1; guard = 0;
    while (pulses < 256 && guard < 14000) begin
      @(posedge clk);
      #1;
      guard++;
      if (done2) begin
        pulses++;
        if (pulses == 255) cnt255 = cnt2;
      end
    end
    chk("tiny done pulses", pulses, 256);
    chk("tiny cnt at 255", cnt255, 255);
    chk("tiny cnt wrap", cnt2, 0);
    en2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
